// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD timer controller:
//   state_e      - controller state encoding (IDLE/RUN/PAUSE/DONE), which is
//                  also the value driven on the 2-bit state output
//   BCD_MAX      - largest legal BCD digit value
//   clamp_digit  - saturates an arbitrary nibble to a legal BCD digit
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Nibbles A..F are not BCD; saturate them to 9 rather than wrapping.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// Combinational next-value logic for one BCD digit of the count chain.
// Ports:
//   digit_i [3:0]  current digit value
//   en_i           step this digit (carry/borrow in; tied high for digit 0)
//   dir_i          0 = increment, 1 = decrement
//   next_o  [3:0]  digit value after the step (equals digit_i when en_i=0)
//   co_o           carry out (up, 9->0) or borrow out (down, 0->9)
// -----------------------------------------------------------------------------
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       en_i,
    input  logic       dir_i,
    output logic [3:0] next_o,
    output logic       co_o
);

    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        next_o = digit_i;
        co_o   = 1'b0;
        if (en_i) begin
            if (!dir_i) begin
                if (digit_i >= BCD_MAX) begin
                    next_o = 4'd0;
                    co_o   = 1'b1;
                end else begin
                    next_o = digit_i + 4'd1;
                end
            end else begin
                if (digit_i == 4'd0) begin
                    next_o = BCD_MAX;
                    co_o   = 1'b1;
                end else begin
                    next_o = digit_i - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_timer_ctrl
// Run/pause/stop timer sequencing a DIGITS-wide BCD count register on one
// clock. Counts up or down on each tick while running, raises a one-cycle done
// pulse when the terminal value (all 9s up, all 0s down) is reached.
// Command priority each cycle: clear > load > stop > start > tick.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   tick            count enable pulse from the prescaler
//   start           start (from IDLE, latches dir) / resume (from PAUSE)
//   stop            pause while running
//   clear           count := 0, back to IDLE
//   load, load_val  load a preset (digits >9 clamped to 9); digit 0 in [3:0]
//   dir             0 = up, 1 = down; latched on start from IDLE
//   count           current BCD count, digit 0 in [3:0]
//   running         registered (state == RUN)
//   done            one-cycle pulse on entry to DONE
//   state           IDLE=0, RUN=1, PAUSE=2, DONE=3
// -----------------------------------------------------------------------------
module bcd_timer_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  dir,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  done,
    output logic [1:0]            state
);

    localparam int W = 4 * DIGITS;

    state_e         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic           dir_q, dir_d;
    logic           running_q, running_d;
    logic           done_q, done_d;

    logic [W-1:0]   step_val;      // count_q advanced one BCD step in dir_q
    logic [DIGITS:0] carry;        // carry/borrow chain between digits
    logic           at_term;       // count_q already terminal for dir_q
    logic           step_term;     // step_val is terminal for dir_q
    logic [W-1:0]   load_clamped;

    function automatic logic is_terminal(input logic [W-1:0] val, input logic down);
        logic term;
        term = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (val[4*i +: 4] != (down ? 4'd0 : BCD_MAX)) term = 1'b0;
        end
        return term;
    endfunction

    // ------------------------------------------------------------------
    // Digit chain: digit 0 always steps, higher digits step on carry-in.
    // ------------------------------------------------------------------
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .digit_i (count_q[4*i +: 4]),
            .en_i    (carry[i]),
            .dir_i   (dir_q),
            .next_o  (step_val[4*i +: 4]),
            .co_o    (carry[i+1])
        );
    end

    // A carry/borrow out of the top digit happens exactly when every digit is
    // at its wrap point, i.e. the count is already terminal for dir_q.
    assign at_term   = carry[DIGITS];
    assign step_term = is_terminal(step_val, dir_q);

    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clamped[4*i +: 4] = clamp_digit(load_val[4*i +: 4]);
        end
    end

    // ------------------------------------------------------------------
    // State register (also holds the count datapath and registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            dir_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; blocking here would create ordering races.
            state_q   <= state_d;
            count_q   <= count_d;
            dir_q     <= dir_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (load) begin
            // RUN and PAUSE keep their state across a load; DONE is released.
            if (state_q == DONE) state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        // Terminal check uses the direction being latched now.
                        state_d = is_terminal(count_q, dir) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (tick && (at_term || step_term)) begin
                        state_d = DONE;
                    end
                end
                PAUSE: begin
                    if (start && !stop) state_d = RUN;
                end
                DONE: begin
                    state_d = DONE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        count_d   = count_q;
        dir_d     = dir_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_clamped;
        end else begin
            if (state_q == IDLE && start && !stop) dir_d = dir;
            // A preloaded terminal value ends the run without stepping past it.
            if (state_q == RUN && !stop && tick && !at_term) count_d = step_val;
        end
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE) && (state_q != DONE);
    end

    assign count   = count_q;
    assign running = running_q;
    assign done    = done_q;
    assign state   = state_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bcd_timer_ctrl
// Self-checking bench: an integer-valued model of the timer tracks the DUT and
// a negedge compare process checks every output each cycle; directed sequences
// pin the model and DUT to hand-computed values, then random commands follow.
// -----------------------------------------------------------------------------
module tb_bcd_timer_ctrl;

    localparam int DIGITS = 4;
    localparam int MAXV   = 9999;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic        clk, rst, tick, start, stop, clear, load, dir;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        running, done;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    bcd_timer_ctrl #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .count    (count),
        .running  (running),
        .done     (done),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (decimal integer count) ----------------
    int m_val = 0;
    int m_st  = S_IDLE;
    bit m_dir = 1'b0;
    bit m_done = 1'b0;

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int load_value(input logic [15:0] lv);
        int v, p;
        v = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            int d;
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic bit term(input int v, input bit down);
        return down ? (v == 0) : (v == MAXV);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_val  = 0;
            m_st   = S_IDLE;
            m_dir  = 1'b0;
            m_done = 1'b0;
        end else begin
            int nv, ns;
            bit nd;
            nv = m_val;
            ns = m_st;
            nd = 1'b0;
            if (clear) begin
                nv = 0;
                ns = S_IDLE;
            end else if (load) begin
                nv = load_value(load_val);
                if (m_st == S_DONE) ns = S_IDLE;
            end else if (m_st == S_IDLE) begin
                if (start && !stop) begin
                    m_dir = dir;
                    if (term(nv, m_dir)) begin ns = S_DONE; nd = 1'b1; end
                    else ns = S_RUN;
                end
            end else if (m_st == S_RUN) begin
                if (stop) ns = S_PAUSE;
                else if (tick) begin
                    if (term(nv, m_dir)) begin ns = S_DONE; nd = 1'b1; end
                    else begin
                        nv = m_dir ? nv - 1 : nv + 1;
                        if (term(nv, m_dir)) begin ns = S_DONE; nd = 1'b1; end
                    end
                end
            end else if (m_st == S_PAUSE) begin
                if (start && !stop) ns = S_RUN;
            end
            m_val  = nv;
            m_st   = ns;
            m_done = nd;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("cmp_count",   32'(count),   to_bcd(m_val));
        check("cmp_state",   32'(state),   32'(m_st));
        check("cmp_running", 32'(running), 32'(m_st == S_RUN));
        check("cmp_done",    32'(done),    32'(m_done));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
        tick  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        load  = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        load_val = v;
        step();
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0;
        clear = 1'b0; load = 1'b0; dir = 1'b0; load_val = '0;
        #3;
        check("rst_count",   32'(count),   32'h0);
        check("rst_state",   32'(state),   32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_done",    32'(done),    32'd0);
        #9 rst = 1'b0;
        @(posedge clk); #2;

        // 1: up count 12 ticks
        dir = 1'b0; start = 1'b1; step();
        for (int i = 0; i < 12; i++) begin tick = 1'b1; step(); end
        check("t1_count", 32'(count), 32'h0012);
        check("t1_state", 32'(state), 32'd1);
        check("t1_done",  32'(done),  32'd0);
        check("t1_model", 32'(m_val), 32'd12);

        // 2: cascade carry 0999 -> 1000
        clear = 1'b1; step();
        do_load(16'h0999);
        dir = 1'b0; start = 1'b1; step();
        tick = 1'b1; step();
        check("t2_count", 32'(count), 32'h1000);
        check("t2_done",  32'(done),  32'd0);
        check("t2_model", 32'(m_val), 32'd1000);

        // 3: down to terminal
        clear = 1'b1; step();
        do_load(16'h0002);
        dir = 1'b1; start = 1'b1; step();
        tick = 1'b1; step();
        check("t3_count1", 32'(count), 32'h0001);
        check("t3_done1",  32'(done),  32'd0);
        tick = 1'b1; step();
        check("t3_count0", 32'(count), 32'h0000);
        check("t3_done",   32'(done),  32'd1);
        check("t3_state",  32'(state), 32'd3);
        step();
        check("t3_done_off", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin tick = 1'b1; start = 1'b1; step(); end
        check("t3_hold",   32'(count), 32'h0000);
        check("t3_state2", 32'(state), 32'd3);

        // 4: pause / resume
        clear = 1'b1; step();
        do_load(16'h0005);
        dir = 1'b0; start = 1'b1; step();
        tick = 1'b1; stop = 1'b1; step();
        check("t4_count", 32'(count), 32'h0005);
        check("t4_state", 32'(state), 32'd2);
        for (int i = 0; i < 3; i++) begin tick = 1'b1; step(); end
        check("t4_paused", 32'(count), 32'h0005);
        start = 1'b1; step();
        tick = 1'b1; step();
        check("t4_resume", 32'(count), 32'h0006);
        check("t4_model",  32'(m_val), 32'd6);

        // 5: priority and clamp
        clear = 1'b1; load = 1'b1; load_val = 16'h1234; tick = 1'b1; step();
        check("t5_count", 32'(count), 32'h0000);
        check("t5_state", 32'(state), 32'd0);
        do_load(16'h1F3A);
        check("t5_clamp", 32'(count), 32'h1939);
        check("t5_model", 32'(m_val), 32'd1939);

        // 6: terminal at start, then async reset mid-run
        do_load(16'h9999);
        dir = 1'b0; start = 1'b1; step();
        check("t6_state", 32'(state), 32'd3);
        check("t6_done",  32'(done),  32'd1);
        check("t6_count", 32'(count), 32'h9999);
        clear = 1'b1; step();
        dir = 1'b0; start = 1'b1; step();
        tick = 1'b1; step();
        tick = 1'b1; step();
        check("t6_run", 32'(count), 32'h0002);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_count", 32'(count), 32'h0000);
        check("t6_rst_state", 32'(state), 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #2;
        dir = 1'b0; start = 1'b1; step();
        check("t6_first_cmd", 32'(state), 32'd1);

        // 7: terminal value loaded while running
        do_load(16'h9999);
        check("t7_still_run", 32'(state), 32'd1);
        tick = 1'b1; step();
        check("t7_state", 32'(state), 32'd3);
        check("t7_done",  32'(done),  32'd1);
        check("t7_count", 32'(count), 32'h9999);

        // random phase
        clear = 1'b1; step();
        for (int n = 0; n < 4000; n++) begin
            clear = ($urandom_range(0, 99) < 2);
            load  = ($urandom_range(0, 99) < 4);
            stop  = ($urandom_range(0, 99) < 6);
            start = ($urandom_range(0, 99) < 15);
            tick  = ($urandom_range(0, 99) < 50);
            dir   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: load_val = 16'($urandom);
                1: load_val = 16'h9990 | 16'($urandom_range(0, 9));
                2: load_val = 16'($urandom_range(0, 9));
                default: load_val = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                                     4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            endcase
            step();
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_timer_ctrl.md
Name: bcd_timer_ctrl

Overview:
Controller that sequences a multi-digit BCD count register as a run/pause/stop timer. It accepts start/stop/clear/load commands and a prescaled tick enable, and counts up or down in BCD with a synchronous ripple carry or borrow across digits. It signals terminal count with a one-cycle done pulse. It sits between front-panel/CPU command logic and the digit display/decoder path, replacing free-running ripple-clocked digit chains with a single-clock design.

Parameters:
DIGITS, 4, number of BCD digits (count width = 4*DIGITS)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
tick  in  1  count enable, one-cycle pulse from prescaler
start  in  1  start/resume command (level, sampled each cycle)
stop  in  1  pause command
clear  in  1  clear count to zero, return to IDLE
load  in  1  load preset value
load_val  in  4*DIGITS  preset, digit 0 in bits [3:0]
dir  in  1  0 = count up, 1 = count down; latched on start from IDLE
count  out  4*DIGITS  current BCD count, digit 0 in [3:0]
running  out  1  high while in RUN
done  out  1  one-cycle pulse on entry to DONE
state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: count=0, state=IDLE, running=0, done=0, dir_q=0.
- Command priority within one cycle: clear > load > stop > start > tick.
- Terminal value:
  - Up: all digits 9.
  - Down: all digits 0.
  - Terminal test uses the latched direction dir_q.
- IDLE:
  - start -> latch dir_q=dir.
  - If count is already terminal for the new dir -> DONE, with done pulsed that cycle. Otherwise -> RUN.
- RUN:
  - tick -> count advances one BCD step, visible the cycle after tick.
  - stop -> PAUSE.
  - start -> ignored.
  - When a tick step produces the terminal value, the same edge moves to DONE and asserts done for one cycle.
- PAUSE:
  - tick -> ignored.
  - start -> RUN; dir is not re-latched.
- DONE:
  - count holds; tick, start and stop are ignored.
  - Exits only via clear or load.
- clear (any state): count=0 -> IDLE next cycle. dir_q is unchanged.
- load, by state:
  - IDLE and DONE: count=load_val -> IDLE.
  - RUN: count=load_val, stays RUN.
  - PAUSE: count=load_val, stays PAUSE.
  - If the loaded value is terminal while in RUN, the next tick does not advance the count; it goes to DONE and pulses done.
- Load sanitising: any load_val digit greater than 9 is clamped to 9 per digit.
- BCD arithmetic:
  - Up: a digit at 9 wraps to 0 and carries into the next digit.
  - Down: a digit at 0 wraps to 9 and borrows from the next digit.
  - Carry/borrow ripples combinationally through all digits within the cycle.
  - No wrap past the terminal value. DONE prevents it.
- Simultaneous events:
  - tick with stop -> no count.
  - tick with clear or load -> the command wins and the tick is dropped.
  - start with stop -> stop wins.
- running = (state==RUN), registered. done is never high for two consecutive cycles.
- Reset asserted mid-run forces all reset values immediately. The first command is accepted on the first edge after rst deasserts.

Decomposition:
- Shared package bcd_pkg:
  - state enum: IDLE, RUN, PAUSE, DONE.
  - BCD_MAX = 4'd9.
  - digit-clamp function.
- One sub-module, bcd_digit:
  - Combinational next-digit logic.
  - Inputs: digit, en, dir.
  - Outputs: next digit, carry/borrow out.
  - Instantiated DIGITS times in a chain.
- FSM and count register live in bcd_timer_ctrl.

Test Plan:
1. Up count: rst, dir=0, start, then 12 ticks -> count=0x0012, state=RUN, done=0.
2. Cascade carry: load 0x0999, dir=0, start, 1 tick -> count=0x1000 next cycle, no done.
3. Down to terminal: load 0x0002, dir=1, start, 2 ticks -> count 0x0001 then 0x0000. done high exactly one cycle with the second update; state=DONE; further ticks leave count=0x0000.
4. Pause/resume: RUN at 0x0005, assert stop with a tick in the same cycle -> count stays 0x0005, state=PAUSE. Three ticks -> unchanged. start, then 1 tick -> 0x0006.
5. Priority and clamp:
   - clear+load+tick in the same cycle in RUN -> count=0x0000, state=IDLE.
   - Then load 0x1F3A -> count=0x1939.
6. Terminal-at-start: load 0x9999, dir=0, start -> state=DONE and done pulse in that cycle with no tick needed. Assert rst mid-RUN -> count=0 and state=IDLE asynchronously.
